// File: rtl/rs_drive_ctrl.sv
// rs_drive_ctrl: debounced set/reset buttons driving a NOR RS latch with
// timed S/R pulses, a Q feedback check, collision reporting and a sticky fault.

module rs_btn_deb #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_i,
    output logic rise_o
);

    localparam logic [7:0] DEB_MAX = 8'(DEB_CYC - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       deb_q;
    logic       deb_d;
    logic       deb_prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Two-flop synchronizer for the raw asynchronous button.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEB_CYC consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = 8'd0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_MAX) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Debounced level, its counter, and a delayed copy for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise_o = deb_q & ~deb_prev_q;

endmodule

module rs_drive_ctrl #(
    parameter int DEB_CYC   = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic set_btn,
    input  logic rst_btn,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic ack,
    output logic err_both,
    output logic fault
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DRV_S = 3'd1;
    localparam logic [2:0] DRV_R = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;

    localparam logic [3:0] PULSE_MAX = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_MAX   = 4'(GAP_LEN - 1);

    logic       rise_s;
    logic       rise_r;
    logic       pend_s_q;
    logic       pend_s_d;
    logic       pend_r_q;
    logic       pend_r_d;
    logic       clr_s;
    logic       clr_r;
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       exp_q;
    logic       exp_d;
    logic       fault_q;
    logic       fault_d;
    logic       s_q;
    logic       r_q;
    logic       busy_q;

    rs_btn_deb #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_s (
        .clk    (clk),
        .nrst   (nrst),
        .btn_i  (set_btn),
        .rise_o (rise_s)
    );

    rs_btn_deb #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_r (
        .clk    (clk),
        .nrst   (nrst),
        .btn_i  (rst_btn),
        .rise_o (rise_r)
    );

    // Sequencer: pick a pending command, drive, gap, then check feedback.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        fault_d = fault_q;
        clr_s   = 1'b0;
        clr_r   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_s_q && pend_r_q) begin
                    clr_s = 1'b1;
                    clr_r = 1'b1;
                end else if (pend_s_q) begin
                    clr_s   = 1'b1;
                    state_d = DRV_S;
                    exp_d   = 1'b1;
                    cnt_d   = 4'd0;
                end else if (pend_r_q) begin
                    clr_r   = 1'b1;
                    state_d = DRV_R;
                    exp_d   = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            DRV_S, DRV_R: begin
                if (cnt_q == PULSE_MAX) begin
                    state_d = GAP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_MAX) begin
                    state_d = CHECK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (q_fb != exp_q) begin
                    fault_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A new edge wins over a same-cycle clear; repeats just stay set.
    always_comb begin
        pend_s_d = rise_s | (pend_s_q & ~clr_s);
        pend_r_d = rise_r | (pend_r_q & ~clr_r);
    end

    // State, pending flags and registered drive outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            exp_q    <= 1'b0;
            fault_q  <= 1'b0;
            pend_s_q <= 1'b0;
            pend_r_q <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            fault_q  <= fault_d;
            pend_s_q <= pend_s_d;
            pend_r_q <= pend_r_d;
            s_q      <= (state_d == DRV_S);
            r_q      <= (state_d == DRV_R);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign fault    = fault_q;
    assign ack      = (state_q == CHECK) && (q_fb == exp_q);
    assign err_both = (state_q == IDLE) && pend_s_q && pend_r_q;

endmodule
